cpu_run_ctrl: RTL

// Run/debug sequencer for the two-stage RISC-V core. Owns the core's reset and pipeline-advance enable.

---
 rtl/cpu_run_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run/debug sequencer for the two-stage RISC-V core. It owns the core's reset
// and its pipeline-advance enable, and lets a host halt, run, single-step or
// run the core for a fixed number of enabled cycles. A fetch-PC breakpoint
// stops the core before the instruction at the breakpoint address is fetched.
//
// Ports
//   clk_i         clock, all logic on the rising edge
//   rst_i         synchronous active-high reset
//   cmd_valid_i   host command valid
//   cmd_ready_o   command accepted when cmd_valid_i & cmd_ready_o
//   cmd_op_i      0=HALT 1=RUN 2=STEP 3=RUN_N
//   cmd_arg_i     enabled-cycle count for RUN_N
//   bp_en_i       breakpoint enable
//   bp_addr_i     breakpoint fetch address
//   pc_fetch_i    core's current fetch PC
//   cpu_rst_n_o   registered active-low reset to the core
//   cpu_en_o      core advances this cycle
//   halted_o      sequencer is in the HALTED state
//   halt_cause_o  0=none/reset 1=command 2=breakpoint 3=count done
//   retired_o     number of enabled cycles since reset (wraps)
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int PC_W        = 12,
    parameter int CNT_W       = 16,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [CNT_W-1:0] cmd_arg_i,
    input  logic             bp_en_i,
    input  logic [PC_W-1:0]  bp_addr_i,
    input  logic [PC_W-1:0]  pc_fetch_i,
    output logic             cpu_rst_n_o,
    output logic             cpu_en_o,
    output logic             halted_o,
    output logic [1:0]       halt_cause_o,
    output logic [31:0]      retired_o
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [2:0] ST_HOLD    = 3'd0;
    localparam logic [2:0] ST_HALTED  = 3'd1;
    localparam logic [2:0] ST_RUNNING = 3'd2;
    localparam logic [2:0] ST_STEP    = 3'd3;
    localparam logic [2:0] ST_COUNT   = 3'd4;

    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_RUN_N = 2'd3;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_CMD  = 2'd1;
    localparam logic [1:0] CAUSE_BP   = 2'd2;
    localparam logic [1:0] CAUSE_DONE = 2'd3;

    logic [2:0]        state_q,    state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              bp_skip_q,  bp_skip_d;
    logic [1:0]        cause_q,    cause_d;
    logic              cpu_rst_n_q;
    logic [31:0]       retired_q;

    logic cmd_acc;
    logic halt_acc;
    logic bp_hit;
    logic active;

    assign cmd_ready_o = (state_q == ST_HALTED) || (state_q == ST_RUNNING) ||
                         (state_q == ST_COUNT);
    assign cmd_acc     = cmd_valid_i & cmd_ready_o;
    assign halt_acc    = cmd_acc & (cmd_op_i == OP_HALT);

    // bp_skip lets the core fetch past the breakpoint it just stopped on.
    assign bp_hit   = bp_en_i & (pc_fetch_i == bp_addr_i) & ~bp_skip_q;
    assign active   = (state_q == ST_RUNNING) || (state_q == ST_COUNT);
    // STEP ignores the breakpoint; free-running states stop before the fetch.
    assign cpu_en_o = (state_q == ST_STEP) | (active & ~bp_hit);

    assign cpu_rst_n_o  = cpu_rst_n_q;
    assign halted_o     = (state_q == ST_HALTED);
    assign halt_cause_o = cause_q;
    assign retired_o    = retired_q;

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path leaves it unassigned (no latches).
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cnt_d      = cnt_q;
        bp_skip_d  = bp_skip_q;
        cause_d    = cause_q;

        case (state_q)
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                if (hold_cnt_q == HOLD_W'(1)) begin
                    state_d = ST_HALTED;
                end
            end

            ST_HALTED: begin
                if (cmd_acc) begin
                    case (cmd_op_i)
                        OP_RUN: begin
                            state_d   = ST_RUNNING;
                            bp_skip_d = 1'b1;
                        end
                        OP_STEP: begin
                            state_d = ST_STEP;
                        end
                        OP_RUN_N: begin
                            if (cmd_arg_i == '0) begin
                                cause_d = CAUSE_DONE;
                            end else begin
                                state_d   = ST_COUNT;
                                cnt_d     = cmd_arg_i;
                                bp_skip_d = 1'b1;
                            end
                        end
                        default: begin
                            cause_d = CAUSE_CMD;
                        end
                    endcase
                end
            end

            ST_STEP: begin
                state_d = ST_HALTED;
                cause_d = CAUSE_CMD;
            end

            ST_RUNNING, ST_COUNT: begin
                bp_skip_d = 1'b0;
                // Priority: breakpoint, then HALT, then count exhaustion.
                // Non-HALT commands accepted here are simply dropped.
                if (bp_hit) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_BP;
                end else if (halt_acc) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_CMD;
                end else if (state_q == ST_COUNT) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_HALTED;
                        cause_d = CAUSE_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= HOLD_W'(HOLD_CYCLES);
            cnt_q       <= '0;
            bp_skip_q   <= 1'b0;
            cause_q     <= CAUSE_NONE;
            cpu_rst_n_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cnt_q       <= cnt_d;
            bp_skip_q   <= bp_skip_d;
            cause_q     <= cause_d;
            // Released together with the first HALTED cycle.
            cpu_rst_n_q <= (state_d != ST_HOLD);
            retired_q   <= retired_q + 32'(cpu_en_o);
        end
    end

endmodule
